// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM command-side blocks.
//   state_e         : burst sequencer state encoding (IDLE/WDATA/MEM/RDATA)
//   SRAM_ADDR_WIDTH : byte-address width of the sram_1Mx8 device (1M bytes)
//   SRAM_DATA_WIDTH : data width of the sram_1Mx8 device
// ----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_MEM   = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 8;

endpackage

// File: rtl/sram_timeout_ctr.sv
// ----------------------------------------------------------------------------
// sram_timeout_ctr
// Wait-cycle counter for a memory request. Clears while i_clr is high,
// counts up while i_en is high, and raises o_expired once the count equals
// TIMEOUT. The count holds at TIMEOUT so the flag cannot alias back to zero.
// Ports:
//   i_clk      : clock, rising edge
//   i_n_reset  : asynchronous active-low reset
//   i_clr      : synchronous clear (count back to zero)
//   i_en       : count one more waiting cycle
//   o_expired  : count has reached TIMEOUT
// ----------------------------------------------------------------------------
module sram_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_n_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Wait-cycle count: clear has priority, saturate at the limit.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_en && (r_cnt != CNT_LIMIT)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_expired = (r_cnt == CNT_LIMIT);

endmodule

// File: rtl/sram_burst_sequencer.sv
// ----------------------------------------------------------------------------
// sram_burst_sequencer
// Splits burst read/write commands into single-byte req/ack accesses for the
// sram_1Mx8 pin driver, streaming write bytes in and read bytes out over
// valid/ready handshakes. A request left unacknowledged for TIMEOUT wait
// cycles aborts the burst with a one-cycle o_err pulse.
// Ports:
//   i_clk, i_n_reset                : clock, async active-low reset
//   i_cmd_valid/o_cmd_ready         : command handshake (ready only in IDLE)
//   i_cmd_write/i_cmd_addr/i_cmd_len: direction, start address, bytes-1
//   i_wdata/i_wvalid/o_wready       : write byte stream in
//   o_rdata/o_rvalid/i_rready       : read byte stream out
//   o_mem_req/o_mem_write/o_mem_addr/o_mem_wdata : access to the SRAM stage
//   i_mem_ack/i_mem_rdata           : access completion, read data
//   o_busy                          : not IDLE
//   o_err                           : one-cycle pulse on timeout abort
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module sram_burst_sequencer
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_mem_req,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_count;   // bytes still to go after the current one
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_in_mem;
  logic w_last;
  logic w_tmo_clr;
  logic w_tmo_en;
  logic w_expired;

  assign w_in_mem = (r_state == ST_MEM);
  assign w_last   = (r_count == LEN_ZERO);

  // The counter sits at zero whenever we are outside MEM, so every MEM entry
  // starts a fresh wait window; it advances only on cycles without an ack.
  assign w_tmo_clr = ~w_in_mem;
  assign w_tmo_en  = w_in_mem & ~i_mem_ack;

  sram_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .i_clk     (i_clk),
    .i_n_reset (i_n_reset),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  // Burst FSM with address incrementer, byte counter and captured data.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_addr  <= ADDR_ZERO;
      r_count <= LEN_ZERO;
      r_wdata <= DATA_ZERO;
      r_rdata <= DATA_ZERO;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_write <= i_cmd_write;
            r_addr  <= i_cmd_addr;
            r_count <= i_cmd_len;
            r_state <= i_cmd_write ? ST_WDATA : ST_MEM;
          end
        end
        ST_WDATA: begin
          if (i_wvalid) begin
            r_wdata <= i_wdata;
            r_state <= ST_MEM;
          end
        end
        ST_MEM: begin
          // An ack in the expiry cycle still completes the access.
          if (i_mem_ack) begin
            if (!r_write) begin
              r_rdata <= i_mem_rdata;
              r_state <= ST_RDATA;
            end else if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_count <= r_count - LEN_ONE;
              r_addr  <= r_addr + ADDR_ONE;   // wraps modulo 2^ADDR_WIDTH
              r_state <= ST_WDATA;
            end
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (i_rready) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_count <= r_count - LEN_ONE;
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= ST_MEM;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_wready    = (r_state == ST_WDATA);
  assign o_rvalid    = (r_state == ST_RDATA);
  assign o_mem_req   = w_in_mem;
  assign o_mem_write = w_in_mem & r_write;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_sram_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sram_burst_sequencer
// Bench for sram_burst_sequencer (TIMEOUT = 4). A transaction-level
// environment plays command source, write producer, read consumer and memory;
// it predicts every cycle's handshake outputs, addresses and data from the
// burst parameters with plain arithmetic and a byte-array memory.
// ----------------------------------------------------------------------------
module tb_sram_burst_sequencer;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int TO = 4;

  logic          clk;
  logic          i_n_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [LW-1:0] i_cmd_len;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid;
  logic          o_wready;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          i_rready;
  logic          o_mem_req;
  logic          o_mem_write;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_busy;
  logic          o_err;

  sram_burst_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk       (clk),
    .i_n_reset   (i_n_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_len   (i_cmd_len),
    .i_wdata     (i_wdata),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .i_rready    (i_rready),
    .o_mem_req   (o_mem_req),
    .o_mem_write (o_mem_write),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;          // completed memory accesses seen on the port
  int first_req;
  int first_rv;
  logic [DW-1:0] last_rd;
  logic [DW-1:0] mem [int];

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    int            len;
    int            dly;      // ack delay in req cycles, -1 = random
    int            to_at;    // byte index that never gets an ack, -1 = none
    int            ws_byte;
    int            ws_n;
    int            rs_byte;
    int            rs_n;
    int            exp_acc;
    int            exp_err;
    int            exp_req_cyc;
    int            exp_rv_cyc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int dly_for(input int n, input int dly, input int to_at);
    if (n == to_at) return 1000;
    if (dly >= 0) return dly;
    return int'($urandom_range(0, TO));
  endfunction

  // Count completed accesses (req and ack together) at the active edge.
  always @(posedge clk) begin
    if (i_n_reset && o_mem_req && i_mem_ack) acc_cnt <= acc_cnt + 1;
  end

  // Run one burst starting at the current negedge (cycle 0 = accept cycle).
  // Phases: 0 idle, 1 waiting write byte, 2 memory access, 3 read byte out.
  task automatic run_burst(input bit wr, input logic [AW-1:0] addr, input int len,
                           input int dly, input int to_at,
                           input int ws_byte, input int ws_n,
                           input int rs_byte, input int rs_n,
                           input bit rnd, output bit got_err);
    int cyc, n, wt, d, ws_left, rs_left, ph, ph_nx;
    bit aborted;
    logic [AW-1:0] a;
    logic [DW-1:0] wb [256];
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < 256; i++) wb[i] = rnd ? DW'($urandom) : DW'((i + 1) * 17);
    first_req = -1;
    first_rv  = -1;
    aborted   = 1'b0;
    exp_rd    = last_rd;
    chk("cmd_ready_at_cmd", 32'(o_cmd_ready), 32'(1));
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = LW'(len);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_addr  = AW'($urandom);
    cyc = 1;
    n   = 0;
    wt  = 0;
    d   = dly_for(0, dly, to_at);
    ws_left = (ws_byte == 0) ? ws_n : 0;
    rs_left = 0;
    ph = wr ? 1 : 2;
    while (ph != 0 && cyc < 5000) begin
      ph_nx = ph;
      chk("wready", 32'(o_wready), 32'(ph == 1));
      chk("mem_req", 32'(o_mem_req), 32'(ph == 2));
      chk("rvalid", 32'(o_rvalid), 32'(ph == 3));
      chk("busy", 32'(o_busy), 32'(1));
      chk("cmd_ready_busy", 32'(o_cmd_ready), 32'(0));
      chk("err_quiet", 32'(o_err), 32'(0));
      i_wvalid    = 1'b0;
      i_mem_ack   = 1'b0;
      i_rready    = 1'b0;
      i_wdata     = DW'($urandom);
      i_mem_rdata = DW'($urandom);
      case (ph)
        1: begin
          if (ws_left > 0) begin
            ws_left--;
          end else if (rnd && $urandom_range(0, 3) == 0) begin
          end else begin
            i_wvalid = 1'b1;
            i_wdata  = wb[n];
            ph_nx    = 2;
            wt       = 0;
            d        = dly_for(n, dly, to_at);
          end
        end
        2: begin
          a = addr + AW'(n);
          if (first_req < 0) first_req = cyc;
          chk("mem_addr", 32'(o_mem_addr), 32'(a));
          chk("mem_write", 32'(o_mem_write), 32'(wr));
          if (wr) chk("mem_wdata", 32'(o_mem_wdata), 32'(wb[n]));
          if (wt == d) begin
            i_mem_ack = 1'b1;
            if (wr) begin
              mem[int'(a)] = wb[n];
              if (n == len) begin
                ph_nx = 0;
              end else begin
                n++;
                ph_nx   = 1;
                ws_left = (n == ws_byte) ? ws_n : 0;
              end
            end else begin
              exp_rd      = mem_rd(a);
              i_mem_rdata = exp_rd;
              ph_nx       = 3;
              rs_left     = (n == rs_byte) ? rs_n : 0;
            end
          end else if (wt == TO) begin
            ph_nx   = 0;
            aborted = 1'b1;
          end else begin
            wt++;
          end
        end
        3: begin
          if (first_rv < 0) first_rv = cyc;
          chk("rdata", 32'(o_rdata), 32'(exp_rd));
          if (rs_left > 0) begin
            rs_left--;
          end else if (rnd && $urandom_range(0, 2) == 0) begin
          end else begin
            i_rready = 1'b1;
            if (n == len) begin
              ph_nx = 0;
            end else begin
              n++;
              ph_nx = 2;
              wt    = 0;
              d     = dly_for(n, dly, to_at);
            end
          end
        end
        default: begin
        end
      endcase
      @(negedge clk);
      cyc++;
      ph = ph_nx;
    end
    i_wvalid  = 1'b0;
    i_mem_ack = 1'b0;
    i_rready  = 1'b0;
    last_rd   = exp_rd;
    chk("burst_budget", 32'(ph), 32'(0));
    chk("end_cmd_ready", 32'(o_cmd_ready), 32'(1));
    chk("end_busy", 32'(o_busy), 32'(0));
    chk("end_mem_req", 32'(o_mem_req), 32'(0));
    chk("end_wready", 32'(o_wready), 32'(0));
    chk("end_rvalid", 32'(o_rvalid), 32'(0));
    chk("end_err", 32'(o_err), 32'(aborted));
    got_err = o_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   e;
    int   a0;
    tbl[0] = '{1'b0, 20'h00010,   0, 2, -1, -1, 0, -1, 0,   1, 0, 1,  4};
    tbl[1] = '{1'b1, 20'h00100,   3, 1, -1,  2, 3, -1, 0,   4, 0, 2, -1};
    tbl[2] = '{1'b0, 20'hFFFFE,   3, 0, -1, -1, 0,  1, 2,   4, 0, 1,  2};
    tbl[3] = '{1'b1, 20'h00200,   2, 1,  0, -1, 0, -1, 0,   0, 1, 2, -1};
    tbl[4] = '{1'b0, 20'h00300,   5, 3,  2, -1, 0, -1, 0,   2, 1, 1,  5};
    tbl[5] = '{1'b1, 20'hFFFFF,   1, 4, -1, -1, 0, -1, 0,   2, 0, 2, -1};
    tbl[6] = '{1'b0, 20'h12345,   0, 4, -1, -1, 0, -1, 0,   1, 0, 1,  6};
    tbl[7] = '{1'b0, 20'hFFF80, 255, 0, -1, -1, 0, -1, 0, 256, 0, 1,  2};

    last_rd     = 8'h00;
    i_n_reset   = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 20'h00000;
    i_cmd_len   = 8'h00;
    i_wdata     = 8'h00;
    i_wvalid    = 1'b0;
    i_rready    = 1'b0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'(1));
    chk("rst_wready", 32'(o_wready), 32'(0));
    chk("rst_rvalid", 32'(o_rvalid), 32'(0));
    chk("rst_mem_req", 32'(o_mem_req), 32'(0));
    chk("rst_mem_write", 32'(o_mem_write), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_err", 32'(o_err), 32'(0));
    chk("rst_mem_addr", 32'(o_mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(o_mem_wdata), 32'(0));
    chk("rst_rdata", 32'(o_rdata), 32'(0));
    i_n_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(o_cmd_ready), 32'(1));
    chk("post_rst_busy", 32'(o_busy), 32'(0));

    // Directed table, bursts issued back to back
    for (int i = 0; i < 8; i++) begin
      a0 = acc_cnt;
      run_burst(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].dly, tbl[i].to_at,
                tbl[i].ws_byte, tbl[i].ws_n, tbl[i].rs_byte, tbl[i].rs_n, 1'b0, e);
      chk("tbl_acc", 32'(acc_cnt - a0), 32'(tbl[i].exp_acc));
      chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
      chk("tbl_req_cyc", 32'(first_req), 32'(tbl[i].exp_req_cyc));
      chk("tbl_rv_cyc", 32'(first_rv), 32'(tbl[i].exp_rv_cyc));
    end

    // Stray ack and unsolicited write/read handshakes while idle
    a0 = acc_cnt;
    i_mem_ack   = 1'b1;
    i_mem_rdata = ~last_rd;
    i_wvalid    = 1'b1;
    i_rready    = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rdata", 32'(o_rdata), 32'(last_rd));
      chk("stray_busy", 32'(o_busy), 32'(0));
      chk("stray_wready", 32'(o_wready), 32'(0));
    end
    i_mem_ack = 1'b0;
    i_wvalid  = 1'b0;
    i_rready  = 1'b0;
    chk("stray_acc", 32'(acc_cnt - a0), 32'(0));

    // Reset in the middle of an unacknowledged read
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 20'h0ABCD;
    i_cmd_len   = 8'd3;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req_before", 32'(o_mem_req), 32'(1));
    chk("mid_addr_before", 32'(o_mem_addr), 32'(20'h0ABCD));
    a0 = acc_cnt;
    #2 i_n_reset = 1'b0;
    #1;
    chk("mid_req_async", 32'(o_mem_req), 32'(0));
    chk("mid_ready_async", 32'(o_cmd_ready), 32'(1));
    chk("mid_addr_async", 32'(o_mem_addr), 32'(0));
    @(negedge clk);
    i_n_reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_after_req", 32'(o_mem_req), 32'(0));
      chk("mid_after_busy", 32'(o_busy), 32'(0));
    end
    chk("mid_after_acc", 32'(acc_cnt - a0), 32'(0));

    // Randomized bursts against the environment model
    for (int k = 0; k < 40; k++) begin
      bit            wr;
      logic [AW-1:0] ra;
      int            len;
      int            to_at;
      wr = 1'($urandom_range(0, 1));
      ra = AW'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 20'hFFFFF - AW'($urandom_range(0, 3));
      len   = int'($urandom_range(0, 9));
      to_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      a0 = acc_cnt;
      run_burst(wr, ra, len, -1, to_at, -1, 0, -1, 0, 1'b1, e);
      chk("rand_acc", 32'(acc_cnt - a0), 32'((to_at < 0) ? len + 1 : to_at));
      chk("rand_err", 32'(e), 32'(to_at >= 0));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_burst_sequencer.md
# sram_burst_sequencer

Command-side sequencer sitting directly upstream of the `sram_1Mx8` pin driver. Accepts burst read/write commands (start address, byte count) from the design core. Breaks each burst into single-byte accesses on a req/ack memory port, incrementing the address per byte. Streams write bytes in and read bytes out over valid/ready handshakes, and aborts a burst with an error pulse if the memory side stalls past a timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, default 20: byte-address width.
- `DATA_WIDTH`, default 8: data width.
- `LEN_WIDTH`, default 8: burst length field width; a burst carries `i_cmd_len`+1 bytes (1..256).
- `TIMEOUT`, default 255: maximum cycles `o_mem_req` may wait for `i_mem_ack`; must be ≥1.

Ports:
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_n_reset` in 1: reset, asynchronous assert, active-low.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: command accepted when both are high.
- `i_cmd_write` in 1: 1 = write burst, 0 = read burst.
- `i_cmd_addr` in ADDR_WIDTH: start byte address.
- `i_cmd_len` in LEN_WIDTH: byte count minus one.
- `i_wdata` in DATA_WIDTH: write byte.
- `i_wvalid` in 1: write byte valid.
- `o_wready` out 1: write byte taken when both are high.
- `o_rdata` out DATA_WIDTH: read byte.
- `o_rvalid` out 1: read byte valid.
- `i_rready` in 1: read byte consumed when both are high.
- `o_mem_req` out 1: access request to the SRAM stage.
- `o_mem_write` out 1: access direction.
- `o_mem_addr` out ADDR_WIDTH: access address.
- `o_mem_wdata` out DATA_WIDTH: access write data.
- `i_mem_ack` in 1: one-cycle pulse; access complete.
- `i_mem_rdata` in DATA_WIDTH: read data, valid in the `i_mem_ack` cycle.
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_err` out 1: one-cycle pulse on timeout abort.

## Operation
- **States:** IDLE, WDATA, MEM, RDATA.
- **IDLE:**
  - `o_cmd_ready`=1 only here.
  - On accept, latch dir, addr, remaining count = `i_cmd_len`.
  - Go to WDATA if write, MEM if read.
- **WDATA:**
  - `o_wready`=1.
  - On `i_wvalid`, latch the byte into `o_mem_wdata` and go to MEM.
- **MEM:**
  - `o_mem_req`=1; addr, dir and wdata are held stable for the whole state.
  - On `i_mem_ack`:
    - Read: capture `i_mem_rdata` into `o_rdata` and go to RDATA.
    - Write, count = 0: go to IDLE.
    - Write, count > 0: decrement count, increment addr, go to WDATA.
- **RDATA:**
  - `o_rvalid`=1.
  - On `i_rready`: if count = 0 go to IDLE; else decrement count, increment addr, go to MEM.
- **Timeout:**
  - Counter clears on MEM entry and increments each MEM cycle without ack.
  - When it reaches TIMEOUT with no ack: pulse `o_err`, drop `o_mem_req`, discard the rest of the burst, go to IDLE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; no error.
- **Address wrap:** addr increment is modulo 2^ADDR_WIDTH (0xFFFFF → 0x00000), with no error.
- **Write bytes outside WDATA** are not accepted (`o_wready`=0); the producer holds them.
- **Stray `i_mem_ack`** while not in MEM is ignored.
- **Reset:**
  - Asserting `i_n_reset` low at any time, including mid-burst, immediately forces IDLE and clears the counters.
  - All outputs go to their reset values; no partial burst resumes after release.

## Timing
- **Reset values:** `o_cmd_ready`=1 (IDLE); `o_wready`, `o_rvalid`, `o_mem_req`, `o_mem_write`, `o_busy`, `o_err`=0; `o_mem_addr`, `o_mem_wdata`, `o_rdata`=0.
- **Decoding:** all handshake outputs decode from the registered state, so there is no combinational path from any input to any output.
- **Cycle numbering:** command accept = cycle 0.
- **Read path:**
  - `o_mem_req` rises in cycle 1.
  - With ack in cycle k, `o_rvalid` and data appear in cycle k+1.
  - With `i_rready` held high, the next `o_mem_req` starts in cycle k+2.
- **Write path:**
  - `o_wready` in cycle 1.
  - With `i_wvalid` in cycle 1, `o_mem_req` rises in cycle 2.
  - With ack in cycle k, `o_wready` again in k+1.
- **Back-to-back commands:** the next command can be accepted in the cycle after the final transition to IDLE.
- **Minimum MEM occupancy:** 1 cycle, with ack in the first req cycle.

## Structure
- Shared package `sram_pkg`:
  - state encoding (IDLE=0, WDATA=1, MEM=2, RDATA=3);
  - default ADDR/DATA widths shared with `sram_1Mx8`.
- Single sub-module `sram_timeout_ctr`: a clear/enable counter with an expiry flag at TIMEOUT.
- FSM, address incrementer and byte counter stay in the top-level module.

## Test plan
- **Reset values:** hold `i_n_reset` low → every output at its reset value and `o_cmd_ready`=1; release → still IDLE.
- **Single read with 2-cycle ack delay:**
  - Stimulus: read, addr 0x00010, len 0; memory acks with 0xA5 two cycles after req.
  - Required: `o_mem_req` in cycle 1; `o_rdata`=0xA5 with `o_rvalid` in cycle 4; back to IDLE after `i_rready`.
- **4-byte write burst:**
  - Stimulus: addr 0x00100, len 3, bytes 11,22,33,44; producer stalls `i_wvalid` 3 cycles before byte 3.
  - Required: four mem writes at 0x00100–0x00103 with matching data; `o_busy` low afterward.
- **Wrap-around read:**
  - Stimulus: addr 0xFFFFE, len 3; consumer deasserts `i_rready` for 2 cycles on byte 2.
  - Required: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; `o_rdata` held stable through the stall.
- **Timeout:**
  - Stimulus: TIMEOUT=4, no ack, write len 2.
  - Required: `o_err` pulses exactly once, `o_mem_req` drops, IDLE; the next command is accepted normally.
- **Reset mid-burst:**
  - Stimulus: assert `i_n_reset` low mid-burst while in MEM.
  - Required: `o_mem_req` falls before the next clock edge; after release, IDLE and no residual accesses.
